trace_nop_event_unit: RTL
=========================

# trace_nop_event_unit

Per-core event extractor that sits directly downstream of a compute tile's execution trace port (one `mor1kx_trace_exec` lane) and upstream of the simulation/debug sinks. It shadows r3 from trace writebacks and decodes special `l.nop` instructions (EXIT, REPORT, PUTC). Matching instructions become events, buffered in a FIFO and offered on a valid/ready stream. It also holds a sticky termination flag and exit code, so the same function exists in synthesizable form rather than testbench-only code.

## Interface
- `ID`, 0, core index, reported on `evt_core_id`
- `FIFO_DEPTH`, 16, event FIFO entries; power of two, ≥2
- `CNT_WIDTH`, 16, width of the dropped-event counter
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `trace_valid`  in  1  trace lane retired an instruction this cycle
- `trace_insn`  in  32  retired instruction word
- `trace_wben`  in  1  retired instruction writes a GPR
- `trace_wbreg`  in  5  destination GPR index
- `trace_wbdata`  in  32  writeback data
- `evt_valid`  out  1  FIFO head is valid
- `evt_ready`  in  1  sink accepts head
- `evt_type`  out  2  0=EXIT, 1=REPORT, 2=PUTC, 3 never produced
- `evt_data`  out  32  event payload
- `evt_core_id`  out  16  constant `ID`
- `terminated`  out  1  sticky: EXIT seen
- `exit_code`  out  32  r3 value captured at EXIT
- `drop_cnt`  out  CNT_WIDTH  events lost to full FIFO, saturating
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- r3 shadow: on `trace_valid & trace_wben & trace_wbreg==3`, load `trace_wbdata`. The reset value is 0.
- Decode: `trace_valid & trace_insn[31:24]==8'h15` is an `l.nop`. K=`trace_insn[15:0]`:
  - 0x0001 → EXIT
  - 0x0002 → REPORT
  - 0x0004 → PUTC
  - any other K → ignored
- An `l.nop` never writes back. Payload is therefore the registered shadow value as it stands before the current cycle:
  - EXIT/REPORT: full r3
  - PUTC: `{24'b0, r3[7:0]}`
- EXIT: pushes an event and sets `terminated`=1. `exit_code`←r3 in the same edge.
- After `terminated`=1, new events are neither pushed nor counted. The r3 shadow continues to update.
- Push rule: accept when `!full | (evt_valid & evt_ready)`. Pop and push in the same cycle while full → accepted, level unchanged.
- Otherwise the event is dropped and `drop_cnt` increments, saturating at all-ones.
- Pop: `evt_valid & evt_ready`. Output is first-word-fall-through from the FIFO head.
- `evt_valid` and all payload outputs hold stable while `evt_valid & !evt_ready`.
- Reset (asserted at any time, including mid-stream): FIFO empties, all outputs go to 0 immediately (asynchronous), pointers clear.
  - Reset values: `evt_valid`=0, `evt_type`=0, `evt_data`=0, `terminated`=0, `exit_code`=0, `drop_cnt`=0, `fifo_level`=0.

## Timing
- Trace cycle N (decoded event) → `evt_valid` high in N+1 when the FIFO was empty; latency 1.
- `terminated` and `exit_code` are visible in N+1.
- `fifo_level` updates on the edge after a push or pop; push+pop in one cycle → no change.
- Back-to-back events every cycle are sustained at one per cycle while the sink holds `evt_ready`=1.
- r3 written in cycle N and `l.nop` in N+1 → the event carries the cycle-N value.
- Pointers wrap modulo FIFO_DEPTH. Full = level==FIFO_DEPTH; empty = level==0.

## Structure
- Package `trace_nop_pkg`:
  - `NOP_EXIT`=16'h0001, `NOP_REPORT`=16'h0002, `NOP_PUTC`=16'h0004, `NOP_OPC`=8'h15
  - `typedef enum logic [1:0] evt_type_t`
  - `typedef struct packed {evt_type_t t; logic [31:0] d;} nop_evt_t`
- Sub-module `nop_evt_fifo`: synchronous FWFT FIFO of `nop_evt_t`, width and depth parameters, async active-low reset. The top level contains only decode, the r3 shadow, and the termination/counter logic.

## Test plan
- Reset release; write r3=0x41 then `l.nop 0x4` → one PUTC event, `evt_data`=0x00000041, `evt_valid` asserted one cycle after the nop.
- r3=0xDEADBEEF, `l.nop 0x2`, then r3=0x7, `l.nop 0x1`, then `l.nop 0x2` → REPORT 0xDEADBEEF, EXIT 0x7, then nothing. `terminated`=1, `exit_code`=0x7.
- DEPTH=4, `evt_ready`=0, six PUTC events → `fifo_level`=4, `drop_cnt`=2. Release ready → four events drain in original order.
- FIFO full with `evt_ready`=1 and a push every cycle → no drops, level stays 4, continuous one-per-cycle output.
- `l.nop 0x0` and `l.nop 0x3`, and 0x15000004 with `trace_valid`=0 → no events, r3 shadow unaffected.
- Assert `rst_n` low mid-drain with 3 entries queued → `evt_valid`, `fifo_level` and `terminated` go to 0 asynchronously; after release, a new PUTC is delivered correctly.

Source files
------------

// File: rtl/trace_nop_pkg.sv
// rtl/trace_nop_pkg.sv - shared constants and event types for the l.nop event unit
// Contents: l.nop opcode and K-field codes, event type enum, event record struct.

package trace_nop_pkg;

   localparam logic [7:0]  NOP_OPC    = 8'h15;
   localparam logic [15:0] NOP_EXIT   = 16'h0001;
   localparam logic [15:0] NOP_REPORT = 16'h0002;
   localparam logic [15:0] NOP_PUTC   = 16'h0004;

   typedef enum logic [1:0] {
      EVT_EXIT   = 2'd0,
      EVT_REPORT = 2'd1,
      EVT_PUTC   = 2'd2
   } evt_type_t;

   typedef struct packed {
      evt_type_t   t;
      logic [31:0] d;
   } nop_evt_t;

   localparam int NOP_EVT_W = $bits(nop_evt_t);

endpackage

// File: rtl/nop_evt_fifo.sv
// rtl/nop_evt_fifo.sv - first-word-fall-through FIFO for decoded l.nop events
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i/data_i   write request and record
//   pop_i           consume head
//   head_valid_o    FIFO not empty
//   head_data_o     head record, forced to zero while empty
//   full_o, level_o occupancy status

module nop_evt_fifo
   import trace_nop_pkg::*;
#(
   parameter int WIDTH = NOP_EVT_W,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic                     head_valid_o,
   output logic [WIDTH-1:0]         head_data_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             empty, do_push, do_pop;

   assign empty   = (level_q == '0);
   assign full_o  = (level_q == LVL_FULL);
   assign do_pop  = pop_i & !empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign do_push = push_i & (!full_o | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is not reset; stale contents are masked by the empty gate below.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_valid_o = !empty;
   assign head_data_o  = empty ? '0 : mem_q[rd_ptr_q];
   assign level_o      = level_q;

endmodule

// File: rtl/trace_nop_event_unit.sv
// rtl/trace_nop_event_unit.sv - decodes EXIT/REPORT/PUTC l.nop from an exec trace lane into an event stream
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   trace_*                     retired instruction and GPR writeback of one trace lane
//   evt_valid/ready/type/data   buffered event stream (first-word-fall-through)
//   evt_core_id                 constant ID
//   terminated, exit_code       sticky EXIT flag and r3 captured at EXIT
//   drop_cnt                    saturating count of events lost to a full FIFO
//   fifo_level                  current FIFO occupancy

module trace_nop_event_unit
   import trace_nop_pkg::*;
#(
   parameter int ID         = 0,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          trace_valid,
   input  logic [31:0]                   trace_insn,
   input  logic                          trace_wben,
   input  logic [4:0]                    trace_wbreg,
   input  logic [31:0]                   trace_wbdata,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [1:0]                    evt_type,
   output logic [31:0]                   evt_data,
   output logic [15:0]                   evt_core_id,
   output logic                          terminated,
   output logic [31:0]                   exit_code,
   output logic [CNT_WIDTH-1:0]          drop_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [31:0]          r3_q, r3_d;
   logic                 terminated_q, terminated_d;
   logic [31:0]          exit_code_q, exit_code_d;
   logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

   logic     is_nop, hit, is_exit, evt_fire, accept, push, pop, fifo_full;
   nop_evt_t new_evt, head;

   assign is_nop = trace_valid & (trace_insn[31:24] == NOP_OPC);

   // The payload uses the registered r3: an l.nop has no writeback of its own,
   // so the shadow already holds the value the program meant to pass.
   always_comb begin
      hit       = 1'b0;
      is_exit   = 1'b0;
      new_evt.t = EVT_EXIT;
      new_evt.d = r3_q;
      case (trace_insn[15:0])
         NOP_EXIT: begin
            hit     = is_nop;
            is_exit = is_nop;
         end
         NOP_REPORT: begin
            hit       = is_nop;
            new_evt.t = EVT_REPORT;
         end
         NOP_PUTC: begin
            hit       = is_nop;
            new_evt.t = EVT_PUTC;
            new_evt.d = {24'b0, r3_q[7:0]};
         end
         default: ;
      endcase
   end

   assign evt_fire = hit & !terminated_q;
   assign pop      = evt_valid & evt_ready;
   assign accept   = !fifo_full | pop;
   assign push     = evt_fire & accept;

   always_comb begin
      r3_d         = r3_q;
      terminated_d = terminated_q;
      exit_code_d  = exit_code_q;
      drop_cnt_d   = drop_cnt_q;
      if (trace_valid & trace_wben & (trace_wbreg == 5'd3)) r3_d = trace_wbdata;
      // Termination does not depend on the EXIT event finding room in the FIFO.
      if (evt_fire & is_exit) begin
         terminated_d = 1'b1;
         exit_code_d  = r3_q;
      end
      if (evt_fire & !accept & (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r3_q         <= '0;
         terminated_q <= 1'b0;
         exit_code_q  <= '0;
         drop_cnt_q   <= '0;
      end else begin
         r3_q         <= r3_d;
         terminated_q <= terminated_d;
         exit_code_q  <= exit_code_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   nop_evt_fifo #(
      .WIDTH (NOP_EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (push),
      .data_i       (new_evt),
      .pop_i        (pop),
      .head_valid_o (evt_valid),
      .head_data_o  (head),
      .full_o       (fifo_full),
      .level_o      (fifo_level)
   );

   assign evt_type    = head.t;
   assign evt_data    = head.d;
   assign evt_core_id = 16'(ID);
   assign terminated  = terminated_q;
   assign exit_code   = exit_code_q;
   assign drop_cnt    = drop_cnt_q;

endmodule
